// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED sequencer/arbiter.
//   Address map, FSM state encoding, register reset defaults and the
//   effective-length helper used by both the RTL and the host model.
package led_seq_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned TBL_DEPTH = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned LEN_W     = 4;

    localparam logic [ADDR_W-1:0] ADDR_LED      = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_LEN      = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_TBL_BASE = 4'h8;

    localparam logic [DATA_W-1:0] PERIOD_RST = 8'h0F;
    localparam logic [DATA_W-1:0] LEN_RST    = 8'h08;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PEND = 3'd2,
        STEP = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    // A LEN field of 0 or above the table depth means "use the whole table".
    function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] len_field);
        if ((len_field == '0) || (len_field > LEN_W'(TBL_DEPTH))) begin
            return LEN_W'(TBL_DEPTH);
        end
        return len_field;
    endfunction

endpackage

// File: rtl/led_seq_arb_if.sv
// Host register bus of the LED sequencer/arbiter.
//   h_cs/h_wr/h_addr/h_wdata : access request from the host (one-cycle strobe)
//   h_rdata/h_ack            : registered response, one cycle after h_cs
interface led_seq_arb_if;
    import led_seq_pkg::*;

    logic              h_cs;
    logic              h_wr;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic [DATA_W-1:0] h_rdata;
    logic              h_ack;

    modport master (output h_cs, h_wr, h_addr, h_wdata, input h_rdata, h_ack);
    modport slave  (input h_cs, h_wr, h_addr, h_wdata, output h_rdata, h_ack);

endinterface

// File: rtl/led_tick_gen.sv
// Step-rate generator for the pattern sequencer.
//   Clk, Rst  : clock and synchronous active-high reset
//   enable    : counters run while high, held at 0 while low
//   period    : a step is requested every period+1 prescaler ticks
//   step_req  : registered one-cycle step request
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESC_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] period,
    output logic              step_req
);

    logic [PRESC_W-1:0] presc;
    logic [DATA_W-1:0]  tcnt;
    logic               tick_c;

    // Tick on prescaler rollover.
    assign tick_c = enable && (&presc);

    // Prescaler and tick counter. A counter left above a freshly lowered
    // period is cleared on the next tick instead of running to wrap.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            presc    <= '0;
            tcnt     <= '0;
            step_req <= 1'b0;
        end else if (!enable) begin
            presc    <= '0;
            tcnt     <= '0;
            step_req <= 1'b0;
        end else begin
            presc    <= presc + PRESC_W'(1);
            step_req <= tick_c && (tcnt == period);
            if (tick_c) begin
                tcnt <= (tcnt >= period) ? '0 : tcnt + DATA_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_arb.sv
// LED register port arbiter with built-in pattern sequencer.
//   Clk, Rst   : clock and synchronous active-high reset
//   hbus       : host register bus (slave side)
//   led_cs     : LED register strobe, one-cycle pulse
//   led_wr     : LED register write, equal to led_cs
//   led_wdata  : LED register write data
//   led_rdata  : current LED register value, returned on host reads of 0x0
module led_seq_arb
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESC_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    led_seq_arb_if.slave      hbus,
    output logic              led_cs,
    output logic              led_wr,
    output logic [DATA_W-1:0] led_wdata,
    input  logic [DATA_W-1:0] led_rdata
);

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;

    logic              seq_en;
    logic              oneshot;
    logic              done;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] len;
    logic [DATA_W-1:0] tbl [TBL_DEPTH];

    logic              step_req;
    logic              tick_en_c;
    logic              host_wr_c;
    logic              host_led_wr_c;
    logic              seq_issue_c;
    logic              done_set_c;
    logic              done_clr_c;
    logic              last_c;
    logic [DATA_W-1:0] rd_mux_c;

    assign host_wr_c     = hbus.h_cs && hbus.h_wr;
    assign host_led_wr_c = host_wr_c && (hbus.h_addr == ADDR_LED);
    assign tick_en_c     = (state == RUN) || (state == PEND) || (state == STEP);
    // ">=" so that a LEN lowered below the current index still wraps.
    assign last_c        = (({1'b0, idx} + LEN_W'(1)) >= len_eff(len[LEN_W-1:0]));

    led_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick (
        .Clk      (Clk),
        .Rst      (Rst),
        .enable   (tick_en_c),
        .period   (period),
        .step_req (step_req)
    );

    // Host read mux; unmapped addresses read as zero.
    always_comb begin
        rd_mux_c = '0;
        case (hbus.h_addr)
            ADDR_LED:    rd_mux_c = led_rdata;
            ADDR_CTRL:   rd_mux_c = {done, 3'(state), 2'b00, oneshot, seq_en};
            ADDR_PERIOD: rd_mux_c = period;
            ADDR_LEN:    rd_mux_c = len;
            default: begin
                if (hbus.h_addr >= ADDR_TBL_BASE) begin
                    rd_mux_c = tbl[hbus.h_addr[IDX_W-1:0]];
                end
            end
        endcase
    end

    // Sequencer next state. A host LED write in the decision cycle holds the
    // step in PEND so the two writes land on consecutive cycles.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        seq_issue_c = 1'b0;
        done_set_c  = 1'b0;
        done_clr_c  = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (seq_en) begin
                    done_clr_c = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (step_req) begin
                    if (host_led_wr_c) begin
                        state_nxt = PEND;
                    end else begin
                        state_nxt   = STEP;
                        seq_issue_c = 1'b1;
                    end
                end
            end
            PEND: begin
                if (!host_led_wr_c) begin
                    state_nxt   = STEP;
                    seq_issue_c = 1'b1;
                end
            end
            STEP: begin
                if (last_c) begin
                    idx_nxt   = '0;
                    state_nxt = oneshot ? DONE : RUN;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = RUN;
                end
            end
            DONE: begin
                done_set_c = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Host disable aborts the run from any state and drops a pending step.
        if (!seq_en && (state != DONE)) begin
            state_nxt   = IDLE;
            idx_nxt     = '0;
            seq_issue_c = 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Control/status registers and pattern table. A completed one-shot run
    // drops both mode bits; a host CTRL write in the same cycle wins.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            seq_en  <= 1'b0;
            oneshot <= 1'b0;
            done    <= 1'b0;
            period  <= PERIOD_RST;
            len     <= LEN_RST;
            for (int i = 0; i < int'(TBL_DEPTH); i++) begin
                tbl[IDX_W'(i)] <= DATA_W'(1) << i;
            end
        end else begin
            if (done_set_c) begin
                done    <= 1'b1;
                seq_en  <= 1'b0;
                oneshot <= 1'b0;
            end else if (done_clr_c) begin
                done <= 1'b0;
            end
            if (host_wr_c) begin
                case (hbus.h_addr)
                    ADDR_CTRL: begin
                        seq_en  <= hbus.h_wdata[0];
                        oneshot <= hbus.h_wdata[1];
                    end
                    ADDR_PERIOD: period <= hbus.h_wdata;
                    ADDR_LEN:    len    <= hbus.h_wdata;
                    default: begin
                        if (hbus.h_addr >= ADDR_TBL_BASE) begin
                            tbl[hbus.h_addr[IDX_W-1:0]] <= hbus.h_wdata;
                        end
                    end
                endcase
            end
        end
    end

    // Host response and LED port. Host and sequencer never issue in the same
    // cycle; the host mux priority is only a safety net.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hbus.h_ack   <= 1'b0;
            hbus.h_rdata <= '0;
            led_cs       <= 1'b0;
            led_wr       <= 1'b0;
            led_wdata    <= '0;
        end else begin
            hbus.h_ack   <= hbus.h_cs;
            hbus.h_rdata <= (hbus.h_cs && !hbus.h_wr) ? rd_mux_c : '0;
            led_cs       <= host_led_wr_c || seq_issue_c;
            led_wr       <= host_led_wr_c || seq_issue_c;
            if (host_led_wr_c) begin
                led_wdata <= hbus.h_wdata;
            end else if (seq_issue_c) begin
                led_wdata <= tbl[idx];
            end
        end
    end

endmodule

// File: tb/tb_led_seq_arb.sv
// Scoreboard bench for led_seq_arb: expected LED writes and read data are
// queued as stimulus is driven and consumed by a monitor on the falling edge.
module tb_led_seq_arb;
    import led_seq_pkg::*;

    localparam int unsigned PRESC_W   = 2;
    localparam int unsigned TICK_CLKS = 1 << PRESC_W;

    logic              Clk       = 1'b0;
    logic              Rst       = 1'b1;
    logic              led_cs;
    logic              led_wr;
    logic [DATA_W-1:0] led_wdata;
    logic [DATA_W-1:0] led_rdata = '0;

    led_seq_arb_if hbus ();

    led_seq_arb #(
        .PRESC_W (PRESC_W)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .hbus      (hbus),
        .led_cs    (led_cs),
        .led_wr    (led_wr),
        .led_wdata (led_wdata),
        .led_rdata (led_rdata)
    );

    always #5 Clk = ~Clk;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int unsigned cyc       = 0;
    logic        cs_prev   = 1'b0;
    logic        rd_prev   = 1'b0;
    int          led_count = 0;
    int unsigned lat       = 7;
    int unsigned k;

    logic [7:0]  exp_led [$];
    logic [7:0]  exp_rd [$];
    int unsigned led_stamps [$];
    logic [7:0]  mdl_tbl [8];
    logic [7:0]  mdl_len;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int tb_len(input logic [7:0] l);
        int v;
        v = int'(l[3:0]);
        return ((v == 0) || (v > 8)) ? 8 : v;
    endfunction

    // Cycle counter, host-access record and external LED register model.
    always @(posedge Clk) begin
        cyc     <= cyc + 1;
        cs_prev <= hbus.h_cs && !Rst;
        rd_prev <= hbus.h_cs && !hbus.h_wr && !Rst;
        if (led_cs === 1'b1) led_rdata <= led_wdata;
    end

    // Monitor: ack timing, read data and LED writes against the queues.
    always @(negedge Clk) begin
        if (cs_prev || (hbus.h_ack === 1'b1)) check_eq("h_ack", 32'(hbus.h_ack), 32'(cs_prev));
        if (rd_prev) begin
            if (exp_rd.size() == 0) check_eq("rd_queue", 32'(exp_rd.size()), 1);
            else check_eq("h_rdata", 32'(hbus.h_rdata), 32'(exp_rd.pop_front()));
        end
        if (led_cs === 1'b1) begin
            led_count++;
            led_stamps.push_back(cyc);
            check_eq("led_wr", 32'(led_wr), 1);
            if (exp_led.size() == 0) check_eq("led_extra", 32'(exp_led.size()), 1);
            else check_eq("led_wdata", 32'(led_wdata), 32'(exp_led.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        hbus.h_cs    = 1'b1;
        hbus.h_wr    = 1'b1;
        hbus.h_addr  = a;
        hbus.h_wdata = d;
        if (a == ADDR_LED) exp_led.push_back(d);
        if (a == ADDR_LEN) mdl_len = d;
        if (a >= ADDR_TBL_BASE) mdl_tbl[a[2:0]] = d;
        @(posedge Clk);
        #1;
        hbus.h_cs = 1'b0;
        hbus.h_wr = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp);
        exp_rd.push_back(exp);
        hbus.h_cs   = 1'b1;
        hbus.h_wr   = 1'b0;
        hbus.h_addr = a;
        @(posedge Clk);
        #1;
        hbus.h_cs = 1'b0;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_tbl[i] = 8'(1 << i);
        mdl_len = 8'h08;
    endtask

    task automatic push_seq(input int n);
        for (int j = 0; j < n; j++) exp_led.push_back(mdl_tbl[j % tb_len(mdl_len)]);
    endtask

    task automatic new_run();
        led_count = 0;
        led_stamps.delete();
    endtask

    task automatic wait_led(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while ((led_count < n) && (i < budget)) begin
            @(posedge Clk);
            i++;
        end
        #1;
        check_eq(tag, 32'(led_count), 32'(n));
    endtask

    task automatic drain(input string tag);
        idle(12);
        check_eq(tag, 32'(exp_led.size()), 0);
    endtask

    initial begin
        hbus.h_cs    = 1'b0;
        hbus.h_wr    = 1'b0;
        hbus.h_addr  = '0;
        hbus.h_wdata = '0;
        mdl_reset();

        // Reset values, then back-to-back register reads.
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_led_cs", 32'(led_cs), 0);
        check_eq("rst_led_wr", 32'(led_wr), 0);
        check_eq("rst_led_wdata", 32'(led_wdata), 0);
        check_eq("rst_h_ack", 32'(hbus.h_ack), 0);
        check_eq("rst_h_rdata", 32'(hbus.h_rdata), 0);
        Rst = 1'b0;
        idle(1);
        host_read(ADDR_CTRL, 8'h00);
        host_read(ADDR_PERIOD, 8'h0F);
        host_read(ADDR_LEN, 8'h08);
        host_read(ADDR_TBL_BASE, 8'h01);
        idle(2);

        // Loop mode, one step per tick, wrapping after entry 7.
        host_write(ADDR_PERIOD, 8'h00);
        new_run();
        push_seq(9);
        k = cyc;
        host_write(ADDR_CTRL, 8'h01);
        wait_led(9, 100, "loop_count");
        host_write(ADDR_CTRL, 8'h00);
        if (led_stamps.size() > 0) lat = led_stamps[0] - k;
        for (int j = 1; j < led_stamps.size(); j++)
            check_eq("loop_gap", led_stamps[j] - led_stamps[j-1], TICK_CLKS);
        drain("loop_drain");

        // One-shot over three entries, then done status.
        host_write(ADDR_LEN, 8'h03);
        host_write(4'h8, 8'hAA);
        host_write(4'h9, 8'h55);
        host_write(4'hA, 8'hFF);
        new_run();
        push_seq(3);
        host_write(ADDR_CTRL, 8'h03);
        wait_led(3, 60, "oneshot_count");
        drain("oneshot_drain");
        host_read(ADDR_CTRL, 8'h80);
        host_write(ADDR_LEN, 8'h08);

        // Host LED write collides with a due step: host first, step next cycle.
        new_run();
        k = cyc;
        host_write(ADDR_CTRL, 8'h01);
        idle(int'(lat) - 2);
        host_write(ADDR_LED, 8'h3C);
        push_seq(2);
        wait_led(3, 60, "arb_count");
        host_write(ADDR_CTRL, 8'h00);
        if (led_stamps.size() >= 3) begin
            check_eq("arb_slip", led_stamps[1] - led_stamps[0], 1);
            check_eq("arb_sched", led_stamps[2] - led_stamps[0], TICK_CLKS);
        end
        drain("arb_drain");
        host_read(ADDR_LED, led_rdata);

        // Disable mid-run after two steps; re-enable restarts at entry 0.
        new_run();
        push_seq(2);
        host_write(ADDR_CTRL, 8'h01);
        wait_led(2, 60, "abort_count");
        host_write(ADDR_CTRL, 8'h00);
        drain("abort_drain");
        host_read(ADDR_CTRL, 8'h00);
        new_run();
        push_seq(1);
        host_write(ADDR_CTRL, 8'h01);
        wait_led(1, 60, "restart_count");
        host_write(ADDR_CTRL, 8'h00);
        drain("restart_drain");

        // PERIOD=1 doubles the step spacing; LEN=0 means the whole table.
        host_write(ADDR_PERIOD, 8'h01);
        host_write(ADDR_LEN, 8'h00);
        host_read(ADDR_LEN, 8'h00);
        host_write(4'h5, 8'h77);
        host_read(4'h5, 8'h00);
        new_run();
        push_seq(9);
        host_write(ADDR_CTRL, 8'h01);
        wait_led(9, 200, "period_count");
        host_write(ADDR_CTRL, 8'h00);
        for (int j = 1; j < led_stamps.size(); j++)
            check_eq("period_gap", led_stamps[j] - led_stamps[j-1], 2 * TICK_CLKS);
        drain("period_drain");

        // Reset one cycle before a step: no LED write, everything back to defaults.
        host_write(ADDR_PERIOD, 8'h00);
        new_run();
        host_write(ADDR_CTRL, 8'h01);
        idle(int'(lat) - 2);
        Rst = 1'b1;
        idle(1);
        Rst = 1'b0;
        mdl_reset();
        check_eq("rstrun_led_cs", 32'(led_cs), 0);
        check_eq("rstrun_led_wdata", 32'(led_wdata), 0);
        check_eq("rstrun_h_ack", 32'(hbus.h_ack), 0);
        idle(12);
        check_eq("rstrun_no_led", 32'(led_count), 0);
        host_read(ADDR_CTRL, 8'h00);
        host_read(ADDR_PERIOD, 8'h0F);
        host_read(ADDR_LEN, 8'h08);
        host_read(ADDR_TBL_BASE, 8'h01);
        idle(3);
        check_eq("rd_drain", 32'(exp_rd.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_seq_arb.md
Name: led_seq_arb

Overview:
- Controller in front of the LED register port (cs/wr/wdata/rdata) of the board LED driver.
- Shares that single write port between the UART-to-SPI host register bus and an internal pattern sequencer.
- The sequencer steps through a host-programmable 8-entry pattern table at a programmable rate, in loop or one-shot mode.
- Also exposes its own control/status registers to the host.

Parameters:
- PRESC_W, 16, width of the free-running prescaler; one tick every 2^PRESC_W clocks.
- TBL_DEPTH, 8, number of pattern table entries (fixed at 8; address map depends on it).

Ports:
- Clk  input  1  system clock
- Rst  input  1  reset, synchronous, active-high
- h_cs  input  1  host access strobe, single-cycle pulse per access
- h_wr  input  1  1 = write, 0 = read; qualified by h_cs
- h_addr  input  4  host register address
- h_wdata  input  8  host write data
- h_rdata  output  8  host read data, valid when h_ack=1
- h_ack  output  1  one-cycle acknowledge for every accepted h_cs
- led_cs  output  1  LED register strobe, single-cycle pulse
- led_wr  output  1  LED register write, equal to led_cs
- led_wdata  output  8  LED register write data
- led_rdata  input  8  current LED register value

Behaviour:
- One clock (Clk); all state reset synchronously by Rst=1.
- Reset values:
  - h_ack=0, h_rdata=0, led_cs=0, led_wr=0, led_wdata=0.
  - CTRL=0, PERIOD=8'h0F, LEN=8, idx=0, prescaler=0, tick count=0.
  - table[i]=1<<i.
  - FSM=IDLE.
- Address map:
  - 0x0 LED: write forwards to the LED port; read returns led_rdata.
  - 0x1 CTRL: [0] seq_en, [1] oneshot, [3:2] reserved (read 0), [7:4] read-only: {done, state[2:0]}.
  - 0x2 PERIOD: step every PERIOD+1 ticks.
  - 0x3 LEN: [3:0] active entries; 0 or values >8 treated as 8; read returns the stored value.
  - 0x8-0xF: pattern table entries 0-7.
  - 0x4-0x7: reads return 0; writes are ignored but still acked.
- Host timing:
  - h_ack and h_rdata are registered one cycle after h_cs.
  - Back-to-back h_cs on consecutive cycles are legal; each gets its own ack.
  - A host write to 0x0 drives led_cs/led_wr/led_wdata in the cycle after h_cs, coincident with h_ack.
- Tick generation: the prescaler free-runs. tick=1 for one cycle when the prescaler rolls over. The tick counter counts ticks and issues a step request when it equals PERIOD, then clears.
- FSM states and transitions:
  - IDLE: seq_en=0; counters held at 0. seq_en 0->1 loads idx=0, clears done, goes to RUN.
  - RUN: counts ticks. A step request goes to STEP, or to PEND if a host LED write is issuing in the same cycle.
  - PEND: waits exactly one cycle, then STEP. The deferred step is not lost.
  - STEP: drives led_cs/led_wr=1 and led_wdata=table[idx].
    - If idx==LEN-1: idx wraps to 0. If oneshot=1, goes to DONE; otherwise back to RUN.
    - Otherwise idx+1, back to RUN.
  - DONE: sets done=1, clears CTRL[0], goes to IDLE on the next cycle.
- Arbitration: the host LED write always wins; the sequencer write slips by one cycle. At most one LED write is issued per cycle.
- Boundaries:
  - seq_en cleared by the host in any state: IDLE next cycle; pending step dropped; idx reset to 0.
  - LEN reduced below idx+1 while running: next step uses entry idx, then wraps to 0.
  - Table write to the entry being stepped in the same cycle: the old value is output; the new value is used on the next visit.
  - PERIOD write while running: takes effect at the next comparison; the tick counter is not cleared. If PERIOD is now below the counter, the counter is cleared on the next tick.
  - Rst asserted mid-sequence: all outputs and registers return to reset values on the next edge; no partial LED write is emitted.

Decomposition:
- Package led_seq_pkg:
  - address constants (ADDR_LED, ADDR_CTRL, ADDR_PERIOD, ADDR_LEN, ADDR_TBL_BASE)
  - FSM state encoding (IDLE=0, RUN=1, PEND=2, STEP=3, DONE=4)
  - reset defaults (PERIOD_RST, LEN_RST)
- Sub-module led_tick_gen: prescaler plus tick counter. Inputs: enable, period. Output: step_req.

Test Plan:
- Reset, then read 0x1, 0x2, 0x3, 0x8 -> h_rdata 0x00, 0x0F, 0x08, 0x01; h_ack one cycle after each h_cs.
- PRESC_W=2, PERIOD=0, write CTRL=0x01 -> led_cs pulses every 4 clocks with wdata 01,02,04,...,80,01 (loop wrap).
- LEN=3, CTRL=0x03 (oneshot), table[0..2]=AA,55,FF -> exactly three LED writes AA,55,FF; then CTRL reads 0x80 (done=1, state IDLE, seq_en=0).
- Host write 0x0=0x3C in the same cycle a step is due -> led_wdata 3C that cycle, sequencer value the next cycle; no step lost.
- Clear seq_en mid-run after 2 steps, then re-enable -> next LED write is table[0].
- Assert Rst one cycle before a STEP -> no led_cs pulse; all outputs 0; CTRL reads 0x00.
